// File: rtl/mips_pkg.sv
// Shared encodings and widths for the execute-stage multiply/divide unit.
package mips_pkg;

  localparam int NB_REG = 32;
  localparam int NB_OP  = 3;
  localparam int NB_CNT = 6;

  typedef enum logic [NB_OP-1:0] {
    MULDIV_MULT  = 3'd0,
    MULDIV_MULTU = 3'd1,
    MULDIV_DIV   = 3'd2,
    MULDIV_DIVU  = 3'd3,
    MULDIV_MTHI  = 3'd4,
    MULDIV_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply, or restoring shift-subtract divide
// when MULDIV_DIVIDER_EN is defined. Accumulator layout is {hi/rem, lo/quot}.
module muldiv_step
  import mips_pkg::*;
(
  input  logic                  i_is_div,
  input  logic [2*NB_REG-1:0]   i_acc,
  input  logic [NB_REG-1:0]     i_opb,
  output logic [2*NB_REG-1:0]   o_acc
);

  logic [NB_REG:0] sum;
`ifdef MULDIV_DIVIDER_EN
  logic [NB_REG:0] rem_sh;
  logic [NB_REG:0] diff;
`else
  logic unused_is_div;
  assign unused_is_div = i_is_div;
`endif

  always_comb begin
    // Carry out of the upper half is shifted back in as the new MSB.
    sum   = {1'b0, i_acc[2*NB_REG-1:NB_REG]} + (i_acc[0] ? {1'b0, i_opb} : '0);
    o_acc = {sum, i_acc[NB_REG-1:1]};
`ifdef MULDIV_DIVIDER_EN
    rem_sh = i_acc[2*NB_REG-1:NB_REG-1];
    diff   = rem_sh - {1'b0, i_opb};
    if (i_is_div) begin
      // diff MSB set means the trial subtraction borrowed: restore.
      if (!diff[NB_REG]) o_acc = {diff[NB_REG-1:0], i_acc[NB_REG-2:0], 1'b1};
      else               o_acc = {rem_sh[NB_REG-1:0], i_acc[NB_REG-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Divide support is compiled in only when MULDIV_DIVIDER_EN is defined.
module ex_muldiv
  import mips_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dunit_clk_en,
  input  logic              i_start,
  input  logic [NB_OP-1:0]  i_op,
  input  logic [NB_REG-1:0] i_rs_data,
  input  logic [NB_REG-1:0] i_rt_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [NB_REG-1:0] o_hi,
  output logic [NB_REG-1:0] o_lo
);

  muldiv_state_e       state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [2*NB_REG-1:0] acc_q, acc_d, acc_step, prod_fixed;
  logic [NB_REG-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic                is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic                done_q, done_d;
  logic                is_signed, rs_neg, rt_neg, req_mul, req_div;
  logic [NB_REG-1:0]   rs_mag, rt_mag;

  muldiv_step u_step (
    .i_is_div (is_div_q),
    .i_acc    (acc_q),
    .i_opb    (opb_q),
    .o_acc    (acc_step)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;

    is_signed  = (i_op == MULDIV_MULT) || (i_op == MULDIV_DIV);
    rs_neg     = is_signed & i_rs_data[NB_REG-1];
    rt_neg     = is_signed & i_rt_data[NB_REG-1];
    rs_mag     = rs_neg ? -i_rs_data : i_rs_data;
    rt_mag     = rt_neg ? -i_rt_data : i_rt_data;
    req_mul    = (i_op == MULDIV_MULT) || (i_op == MULDIV_MULTU);
`ifdef MULDIV_DIVIDER_EN
    req_div    = (i_op == MULDIV_DIV) || (i_op == MULDIV_DIVU);
`else
    req_div    = 1'b0;
`endif
    prod_fixed = neg_q ? -acc_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (req_mul || req_div) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            is_div_d  = req_div;
            acc_d     = {{NB_REG{1'b0}}, req_div ? rs_mag : rt_mag};
            opb_d     = req_div ? rt_mag : rs_mag;
            // A zero divisor must leave the all-ones quotient uncorrected.
            neg_d     = (rs_neg ^ rt_neg) & ~(req_div && (i_rt_data == '0));
            rem_neg_d = rs_neg;
          end else if (i_op == MULDIV_MTHI) begin
            hi_d = i_rs_data;
          end else if (i_op == MULDIV_MTLO) begin
            lo_d = i_rs_data;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NB_CNT'(NB_REG - 1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q     ? -acc_q[NB_REG-1:0]        : acc_q[NB_REG-1:0];
          hi_d = rem_neg_q ? -acc_q[2*NB_REG-1:NB_REG] : acc_q[2*NB_REG-1:NB_REG];
        end else begin
          {hi_d, lo_d} = prod_fixed;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (i_dunit_clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule
